// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  // A disabled timeout (0) still needs a 1-bit counter to keep widths legal.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes a sync/length/data/checksum frame into
// instruction memory and holds the CPU in reset until the frame verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 6,
  parameter int unsigned         DATA_W    = 8,
  parameter logic [DATA_W-1:0]   SYNC_BYTE = 8'hA5,
  parameter int unsigned         TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned TW    = timer_width(TIMEOUT);

  state_e            state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              xfer;
  logic              in_frame;

  assign xfer = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    csum_d   = csum_q;
    timer_d  = '0;
    we_d     = 1'b0;
    addr_d   = mem_addr;
    data_d   = mem_data;
    in_frame = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);

    if (in_frame) begin
      timer_d = xfer ? '0 : timer_q + TW'(1);
    end

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (xfer && (in_data == SYNC_BYTE)) state_d = StLen;
      end
      StLen: begin
        if (xfer) begin
          if ((in_data != '0) && (32'(in_data) <= DEPTH)) begin
            len_d   = CW'(in_data);
            count_d = '0;
            csum_d  = '0;
            state_d = StData;
          end else begin
            state_d = StErr;
          end
        end
      end
      StData: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = in_data;
          csum_d  = csum_q ^ in_data;
          count_d = count_q + CW'(1);
          if (count_q + CW'(1) == len_q) state_d = StCsum;
        end
      end
      StCsum: begin
        if (xfer) state_d = (in_data == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase

    // A stall of TIMEOUT cycles inside a frame abandons it.
    if ((TIMEOUT != 0) && in_frame && !xfer && (timer_q == TW'(TIMEOUT))) begin
      state_d = StErr;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      count_q  <= '0;
      csum_q   <= '0;
      timer_q  <= '0;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      count_q  <= count_d;
      csum_q   <= csum_d;
      timer_q  <= timer_d;
      in_ready <= 1'b1;
      mem_we   <= we_d;
      mem_addr <= addr_d;
      mem_data <= data_d;
      cpu_rst  <= (state_d != StDone);
      done     <= (state_d == StDone);
      err      <= (state_d == StErr);
    end
  end

endmodule
